// File: rtl/mdu_seq_if.sv
// mdu_seq_if: request/response bundle between the execute stage (master) and mdu_seq (slave).
interface mdu_seq_if #(parameter int XLEN = 32);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            ready;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    modport master (output start, flush, funct3, op_a, op_b, input ready, busy, done, result);
    modport slave (input start, flush, funct3, op_a, op_b, output ready, busy, done, result);
endinterface

// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide unit, radix-2 shift-add / restoring divide over XLEN cycles.
// Define MDU_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow directly at start.
module mdu_seq #(parameter int XLEN = 32) (
    input  logic     clk,
    input  logic     rst_n,
    mdu_seq_if.slave bus
);
    localparam int CW = $clog2(XLEN);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t            state, nxt;
    logic [2:0]        op;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, step, prod;
    logic [XLEN-1:0]   m, a_raw, a_abs, b_abs, q, r, fix_val;
    logic [XLEN:0]     sum, sh, diff;
    logic              neg_res, neg_rem, div0, ovf;
    logic              a_sgn, b_sgn, a_neg, b_neg, s_div0, s_ovf, accept, fast;
    always_comb begin
        a_sgn  = bus.funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b110};
        b_sgn  = bus.funct3 inside {3'b000, 3'b001, 3'b100, 3'b110};
        a_neg  = a_sgn & bus.op_a[XLEN-1];
        b_neg  = b_sgn & bus.op_b[XLEN-1];
        a_abs  = a_neg ? -bus.op_a : bus.op_a;
        b_abs  = b_neg ? -bus.op_b : bus.op_b;
        s_div0 = bus.funct3[2] & (bus.op_b == '0);
        s_ovf  = bus.funct3[2] & ~bus.funct3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&bus.op_b);
    end
`ifdef MDU_FAST_SPECIAL_EN
    logic [XLEN-1:0] spec_val;
    assign fast     = s_div0 | s_ovf;
    assign spec_val = bus.funct3[1] ? (s_div0 ? bus.op_a : '0) : (s_div0 ? '1 : bus.op_a);
`else
    assign fast = 1'b0;
`endif
    // One datapath step: multiply adds m into the high half then shifts right,
    // divide shifts the remainder left and keeps the subtraction only if it did not borrow.
    always_comb begin
        sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
        sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff = sh - {1'b0, m};
        step = op[2] ? (diff[XLEN] ? {sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                   : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1})
                     : {sum, acc[XLEN-1:1]};
    end
    always_comb begin
        prod    = neg_res ? -acc : acc;
        q       = neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        r       = neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_val = !op[2] ? (op[1:0] == 2'b00 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN])
                : div0   ? (op[1] ? a_raw : '1)
                : ovf    ? (op[1] ? '0 : a_raw)
                : op[1]  ? r : q;
    end
    always_comb begin
        accept = (state == IDLE || state == DONE) && bus.start && !bus.flush;
        nxt    = (state == CALC || state == FIX)
               ? (bus.flush ? IDLE : state == FIX ? DONE : cnt == '0 ? FIX : CALC)
               : (accept ? (fast ? DONE : CALC) : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            cnt        <= '0;
            acc        <= '0;
            m          <= '0;
            a_raw      <= '0;
            neg_res    <= 1'b0;
            neg_rem    <= 1'b0;
            div0       <= 1'b0;
            ovf        <= 1'b0;
            bus.result <= '0;
            bus.busy   <= 1'b0;
            bus.ready  <= 1'b1;
            bus.done   <= 1'b0;
        end else begin
            state     <= nxt;
            bus.busy  <= nxt == CALC || nxt == FIX;
            bus.ready <= !(nxt == CALC || nxt == FIX);
            bus.done  <= nxt == DONE;
            if (accept) begin
                op      <= bus.funct3;
                cnt     <= CW'(XLEN - 1);
                acc     <= {{XLEN{1'b0}}, bus.funct3[2] ? a_abs : b_abs};
                m       <= bus.funct3[2] ? b_abs : a_abs;
                a_raw   <= bus.op_a;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                div0    <= s_div0;
                ovf     <= s_ovf;
`ifdef MDU_FAST_SPECIAL_EN
                if (fast) bus.result <= spec_val;
`endif
            end else if (state == CALC) begin
                acc <= step;
                cnt <= cnt - 1'b1;
            end else if (state == FIX && !bus.flush) begin
                bus.result <= fix_val;
            end
        end
    end
endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: randomized and directed checks of mdu_seq against an arithmetic reference model.
module tb_mdu_seq;
    localparam int XLEN = 32;
`ifdef MDU_FAST_SPECIAL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif
    localparam int LAT = XLEN + 2;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;
    mdu_seq_if #(.XLEN(XLEN)) bus ();
    mdu_seq #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ub = longint'(b);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: return b == 0 ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
            3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
            3'd6: return b == 0 ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
            default: return b == 0 ? a : a % b;
        endcase
    endfunction

    function automatic bit special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int dcyc, output int bcnt);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.funct3 = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
        dcyc = -1; bcnt = 0; res = 'x;
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            @(negedge clk);
            if (bus.busy) bcnt++;
            if (bus.done) begin dcyc = c; res = bus.result; end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks += 4;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", bus.ready); end
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
        if (bus.result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h expected 0", bus.result); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [2:0]  tf[12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd7, 3'd4, 3'd6};
        logic [31:0] ta[12] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                32'd100, 32'd100, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] tb[12] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd2,
                                32'd7, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] te[12] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                                32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
        logic [31:0] res;
        int dcyc, bcnt, elat;
        for (int i = 0; i < 12; i++) begin
            do_op(tf[i], ta[i], tb[i], res, dcyc, bcnt);
            elat = (FAST && i >= 8) ? 1 : LAT;
            checks += 4;
            if (res !== te[i]) begin errors++; $display("FAIL vec%0d_result: got %h expected %h", i, res, te[i]); end
            if (dcyc != elat) begin errors++; $display("FAIL vec%0d_latency: got %0d expected %0d", i, dcyc, elat); end
            if (bcnt != elat - 1) begin errors++; $display("FAIL vec%0d_busy_cycles: got %0d expected %0d", i, bcnt, elat - 1); end
            @(negedge clk);
            if (bus.done !== 1'b0 || bus.result !== te[i]) begin
                errors++; $display("FAIL vec%0d_after_done: done %b result %h expected done 0 result %h", i, bus.done, bus.result, te[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f;
        logic [31:0] a, b, res, exp;
        int dcyc, bcnt, elat, mode;
        for (int i = 0; i < 60; i++) begin
            f = 3'($urandom); a = $urandom; b = $urandom; mode = $urandom_range(0, 5);
            if (mode == 0) b = 0;
            if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (mode == 2) b = $urandom_range(1, 17);
            exp = model(f, a, b);
            elat = (FAST && special(f, a, b)) ? 1 : LAT;
            do_op(f, a, b, res, dcyc, bcnt);
            checks += 2;
            if (res !== exp) begin errors++; $display("FAIL rand%0d_result f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, res, exp); end
            if (dcyc != elat) begin errors++; $display("FAIL rand%0d_latency: got %0d expected %0d", i, dcyc, elat); end
        end
    endtask

    task automatic test_ignored_start();
        logic [31:0] a, b, exp;
        int dcyc = -1;
        a = $urandom; b = $urandom; exp = model(3'd1, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd1; bus.op_a = a; bus.op_b = b;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            @(negedge clk);
            if (c == 5) begin
                checks++;
                if (bus.ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b expected 0", bus.ready); end
                bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = $urandom; bus.op_b = $urandom;
            end
            if (c == 6) bus.start = 1'b0;
            if (bus.done) dcyc = c;
        end
        checks += 2;
        if (bus.result !== exp) begin errors++; $display("FAIL ignored_start_result: got %h expected %h", bus.result, exp); end
        if (dcyc != LAT) begin errors++; $display("FAIL ignored_start_latency: got %0d expected %0d", dcyc, LAT); end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        int dones = 0;
        @(negedge clk);
        prev = bus.result;
        bus.start = 1'b1; bus.funct3 = 3'd5; bus.op_a = $urandom; bus.op_b = $urandom | 32'h1;
        @(posedge clk); #1 bus.start = 1'b0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (bus.done) dones++;
            if (c == 10) bus.flush = 1'b1;
            if (c == 11) begin
                bus.flush = 1'b0;
                checks += 2;
                if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b expected 0", bus.busy); end
                if (bus.ready !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b expected 1", bus.ready); end
            end
        end
        bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
        @(negedge clk);
        bus.start = 1'b0; bus.flush = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_over_start_busy: got %b expected 0", bus.busy); end
        repeat (40) begin @(negedge clk); if (bus.done) dones++; end
        checks += 2;
        if (dones != 0) begin errors++; $display("FAIL flush_done_count: got %0d expected 0", dones); end
        if (bus.result !== prev) begin errors++; $display("FAIL flush_result: got %h expected %h", bus.result, prev); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a1, b1, a2, b2, res;
        int dcyc = -1, bcnt;
        a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom | 32'h1;
        do_op(3'd0, a1, b1, res, dcyc, bcnt);
        checks++;
        if (res !== model(3'd0, a1, b1)) begin errors++; $display("FAIL b2b_first_result: got %h expected %h", res, model(3'd0, a1, b1)); end
        bus.start = 1'b1; bus.funct3 = 3'd7; bus.op_a = a2; bus.op_b = b2;
        @(posedge clk); #1 bus.start = 1'b0;
        dcyc = -1;
        for (int c = 1; c <= 60 && dcyc < 0; c++) begin
            @(negedge clk);
            if (bus.done) dcyc = c;
        end
        checks += 2;
        if (dcyc != LAT) begin errors++; $display("FAIL b2b_latency: got %0d expected %0d", dcyc, LAT); end
        if (bus.result !== model(3'd7, a2, b2)) begin errors++; $display("FAIL b2b_second_result: got %h expected %h", bus.result, model(3'd7, a2, b2)); end
    endtask

    task automatic test_async_reset();
        logic [31:0] res;
        int dcyc, bcnt, dones = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = $urandom | 32'h100; bus.op_b = 32'd3;
        @(posedge clk); #1 bus.start = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks += 3;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL async_reset_busy: got %b expected 0", bus.busy); end
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready: got %b expected 1", bus.ready); end
        if (bus.result !== 32'h0) begin errors++; $display("FAIL async_reset_result: got %h expected 0", bus.result); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (bus.done) dones++; end
        checks++;
        if (dones != 0) begin errors++; $display("FAIL async_reset_done_count: got %0d expected 0", dones); end
        do_op(3'd0, 32'd3, 32'd4, res, dcyc, bcnt);
        checks += 2;
        if (res !== 32'd12) begin errors++; $display("FAIL post_reset_mul: got %h expected %h", res, 32'd12); end
        if (dcyc != LAT) begin errors++; $display("FAIL post_reset_latency: got %0d expected %0d", dcyc, LAT); end
    endtask

    initial begin
        bus.start = 1'b0; bus.flush = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0;
        test_reset();
        test_vectors();
        test_random();
        test_ignored_start();
        test_flush();
        test_back_to_back();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
